// File: rtl/xpb_accum.sv
// rtl/xpb_accum.sv - carry-save accumulator of base + xpb terms, resolved limb-serially.
// Optional XPB_ACC_CHECK_EN adds the sticky err output for protocol misuse.
module xpb_accum #(
  parameter int WORD_W    = 1024,
  parameter int NUM_TERMS = 32,
  parameter int GUARD_W   = 6,
  parameter int LIMB_W    = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WORD_W-1:0]           base_in,
  input  logic                        term_valid,
  input  logic [WORD_W-1:0]           term_in,
  input  logic                        term_last,
  output logic                        busy,
  output logic                        sum_valid,
  output logic [WORD_W+GUARD_W-1:0]   sum_out
`ifdef XPB_ACC_CHECK_EN
  ,
  output logic                        err
`endif
);

  localparam int OUT_W = WORD_W + GUARD_W;
  localparam int NL    = (OUT_W + LIMB_W - 1) / LIMB_W;
  localparam int PAD_W = NL * LIMB_W;
  localparam int RES_W = PAD_W - LIMB_W;
  localparam int CNT_W = $clog2(NUM_TERMS + 2);
  localparam int IDX_W = (NL > 1) ? $clog2(NL) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_RESOLVE,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [OUT_W-1:0]  r_s;
  logic [OUT_W-1:0]  r_c;
  logic [OUT_W-1:0]  r_sum;
  logic [RES_W-1:0]  r_res;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_carry;

  logic [OUT_W-1:0]  w_t;
  logic [OUT_W-1:0]  w_s_nxt;
  logic [OUT_W-1:0]  w_c_nxt;
  logic [LIMB_W:0]   w_limb_sum;
  logic [PAD_W-1:0]  w_res_nxt;
  logic              w_last_limb;

  assign w_t         = {{GUARD_W{1'b0}}, term_in};
  assign w_s_nxt     = r_s ^ r_c ^ w_t;
  assign w_c_nxt     = ((r_s & r_c) | (r_s & w_t) | (r_c & w_t)) << 1;
  // S and C are shifted down during RESOLVE, so the active limb is always at bit 0.
  assign w_limb_sum  = {1'b0, r_s[LIMB_W-1:0]} + {1'b0, r_c[LIMB_W-1:0]}
                     + {{LIMB_W{1'b0}}, r_carry};
  // Result limbs enter from the top; after NL limbs the low OUT_W bits hold the sum.
  assign w_res_nxt   = {w_limb_sum[LIMB_W-1:0], r_res};
  assign w_last_limb = (r_idx == IDX_W'(NL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    sum_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_ACCUM;
      end
      ST_ACCUM: begin
        busy = 1'b1;
        if (term_valid && term_last) w_state_nxt = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        busy = 1'b1;
        if (w_last_limb) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        sum_valid   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s     <= '0;
      r_c     <= '0;
      r_sum   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_s   <= {{GUARD_W{1'b0}}, base_in};
            r_c   <= '0;
            r_cnt <= '0;
          end
        end
        ST_ACCUM: begin
          r_idx   <= '0;
          r_carry <= 1'b0;
          if (term_valid) begin
            r_s <= w_s_nxt;
            r_c <= w_c_nxt;
            if (r_cnt != CNT_W'(NUM_TERMS + 1)) r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESOLVE: begin
          r_s   <= r_s >> LIMB_W;
          r_c   <= r_c >> LIMB_W;
          r_res <= w_res_nxt[PAD_W-1:LIMB_W];
          if (w_last_limb) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= w_res_nxt[OUT_W-1:0];
          end else begin
            r_idx   <= r_idx + IDX_W'(1);
            r_carry <= w_limb_sum[LIMB_W];
          end
        end
        default: ;
      endcase
    end
  end

  assign sum_out = r_sum;

`ifdef XPB_ACC_CHECK_EN
  logic r_err;

  // Setting wins over the clear so a stray term in the start cycle is still flagged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) r_err <= 1'b0;
      if (term_valid && r_state != ST_ACCUM) r_err <= 1'b1;
      if (term_valid && r_state == ST_ACCUM && r_cnt == CNT_W'(NUM_TERMS)) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

endmodule

// File: tb/tb_xpb_accum.sv
// tb/tb_xpb_accum.sv - directed self-checking bench for xpb_accum.
// Build with XPB_ACC_CHECK_EN defined to also exercise the err output.
module tb_xpb_accum;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1023:0] base_in;
  logic          term_valid;
  logic [1023:0] term_in;
  logic          term_last;
  logic          busy;
  logic          sum_valid;
  logic [1029:0] sum_out;
`ifdef XPB_ACC_CHECK_EN
  logic          err;
`endif

  int total = 0;
  int bad   = 0;

  xpb_accum dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_in    (base_in),
    .term_valid (term_valid),
    .term_in    (term_in),
    .term_last  (term_last),
    .busy       (busy),
    .sum_valid  (sum_valid),
    .sum_out    (sum_out)
`ifdef XPB_ACC_CHECK_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1029:0] obs, input logic [1029:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=hi:%0h lo:%0h exp=hi:%0h lo:%0h", tag,
             obs[1029:960], obs[127:0], exp[1029:960], exp[127:0]);
    end
  endtask

  task automatic do_start(input logic [1023:0] b);
    start   = 1'b1;
    base_in = b;
    tick();
    start   = 1'b0;
  endtask

  task automatic send_term(input logic [1023:0] t, input logic last);
    term_valid = 1'b1;
    term_in    = t;
    term_last  = last;
    tick();
    term_valid = 1'b0;
    term_last  = 1'b0;
  endtask

  task automatic wait_result(output int n, output logic held);
    logic [1029:0] prev;
    prev = sum_out;
    held = 1'b1;
    n    = 0;
    while (!sum_valid && n < 100) begin
      tick();
      n++;
      if (!sum_valid && sum_out !== prev) held = 1'b0;
    end
  endtask

  logic [1029:0] exp_v;
  logic [1023:0] t4 [5];
  logic          held;
  int            n;
  int            seen;

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    base_in    = '0;
    term_valid = 1'b0;
    term_in    = '0;
    term_last  = 1'b0;
    tick();
    tick();
    check("rst_busy",      1030'(busy),      1030'(0));
    check("rst_sum_valid", 1030'(sum_valid), 1030'(0));
    check("rst_sum_out",   sum_out,          1030'(0));
    rst = 1'b0;
    tick();

    // 1: base 0 + term 1; latency counted from the absorb cycle
    do_start('0);
    check("t1_busy_after_start", 1030'(busy), 1030'(1));
    send_term(1024'(1), 1'b1);
    wait_result(n, held);
    check("t1_latency",   1030'(n + 1),     1030'(18));
    check("t1_held",      1030'(held),      1030'(1));
    check("t1_sum",       sum_out,          1030'(1));
    check("t1_busy_done", 1030'(busy),      1030'(0));

    // start during DONE is ignored, then accepted one cycle later
    start   = 1'b1;
    base_in = {960'b0, 64'hFFFF_FFFF_FFFF_FFFF};
    tick();
    check("done_start_ignored", 1030'(busy), 1030'(0));
    check("t1_pulse_one_cycle", 1030'(sum_valid), 1030'(0));
    check("t1_sum_held",        sum_out, 1030'(1));
    tick();
    start = 1'b0;
    check("done_start_next", 1030'(busy), 1030'(1));

    // 2: carry crosses limb 0 into limb 1
    send_term(1024'(1), 1'b1);
    wait_result(n, held);
    exp_v = 1030'(1) << 64;
    check("t2_sum", sum_out, exp_v);
    tick();

    // 3: 32 all-ones terms on an all-ones base, no truncation
    do_start({1024{1'b1}});
    for (int i = 0; i < 32; i++) send_term({1024{1'b1}}, i == 31);
    wait_result(n, held);
    exp_v = (1030'(1) << 1029) + (1030'(1) << 1024) - 1030'(33);
    check("t3_sum", sum_out, exp_v);
    tick();

    // 4: five terms with random gaps
    t4[0] = {16{64'h0123_4567_89AB_CDEF}};
    t4[1] = {16{64'hFEDC_BA98_7654_3210}};
    t4[2] = {1024{1'b1}};
    t4[3] = {32'h8000_0001, 960'b0, 32'hDEAD_BEEF};
    t4[4] = {512'b0, {512{1'b1}}};
    do_start({8{128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9999_6666}});
    exp_v = {6'b0, base_in};
    for (int k = 0; k < 5; k++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      send_term(t4[k], k == 4);
      exp_v = exp_v + {6'b0, t4[k]};
    end
    wait_result(n, held);
    check("t4_latency", 1030'(n + 1), 1030'(18));
    check("t4_sum",     sum_out,      exp_v);
    tick();

    // 5: reset in the third ACCUM cycle aborts the operation
    do_start(1024'(100));
    send_term(1024'(3), 1'b0);
    send_term(1024'(4), 1'b0);
    #2 rst = 1'b1;
    #1;
    check("t5_busy_rst", 1030'(busy), 1030'(0));
    check("t5_sum_rst",  sum_out,     1030'(0));
    tick();
    rst  = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (sum_valid) seen++;
    end
    check("t5_no_valid", 1030'(seen), 1030'(0));
    do_start(1024'(7));
    send_term(1024'(5), 1'b1);
    wait_result(n, held);
    check("t5_sum", sum_out, 1030'(12));
    tick();

    // 6: start and a term during RESOLVE, then a term in IDLE
    do_start(1024'(10));
    send_term(1024'(20), 1'b1);
    tick();
    tick();
    start = 1'b1;
    send_term(1024'(999), 1'b1);
    start = 1'b0;
    wait_result(n, held);
    check("t6_sum", sum_out, 1030'(30));
    tick();
    send_term(1024'(77), 1'b1);
    check("t6_idle_term_busy", 1030'(busy), 1030'(0));
`ifdef XPB_ACC_CHECK_EN
    check("t6_err_set",    1030'(err), 1030'(1));
    tick();
    check("t6_err_sticky", 1030'(err), 1030'(1));
`endif
    do_start(1024'(1));
`ifdef XPB_ACC_CHECK_EN
    check("t6_err_clear", 1030'(err), 1030'(0));
`endif
    send_term(1024'(1), 1'b1);
    wait_result(n, held);
    check("t6_after_sum", sum_out, 1030'(2));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
